// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load formatting and writeback-data select.
// Register-file write port and the retired-instruction counter come straight from flops.
module writeback_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned COUNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [1:0]            mem_wb_sel,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic [DATA_W-1:0]     mem_load_data,
  input  logic [2:0]            mem_load_type,
  input  logic [1:0]            mem_addr_lo,
  input  logic [DATA_W-1:0]     mem_pc_plus4,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0]     WriteData,
  output logic                  wb_valid,
  output logic [COUNT_W-1:0]    retired_count
);

  localparam logic [2:0] LdLh  = 3'b001;
  localparam logic [2:0] LdLhu = 3'b010;
  localparam logic [2:0] LdLb  = 3'b011;
  localparam logic [2:0] LdLbu = 3'b100;

  localparam logic [1:0] SelLoad = 2'b01;
  localparam logic [1:0] SelLink = 2'b10;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_value;
  logic [DATA_W-1:0] wb_data;

  // Little-endian lanes; halfword select ignores addr_lo[0].
  assign ld_byte = mem_load_data[{mem_addr_lo, 3'b000} +: 8];
  assign ld_half = mem_load_data[{mem_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_value = mem_load_data;
    case (mem_load_type)
      LdLh:    ld_value = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LdLhu:   ld_value = {{(DATA_W-16){1'b0}}, ld_half};
      LdLb:    ld_value = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LdLbu:   ld_value = {{(DATA_W-8){1'b0}}, ld_byte};
      default: ld_value = mem_load_data;
    endcase
  end

  always_comb begin
    wb_data = mem_alu_result;
    case (mem_wb_sel)
      SelLoad: wb_data = ld_value;
      SelLink: wb_data = mem_pc_plus4;
      default: wb_data = mem_alu_result;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      wb_valid      <= 1'b0;
      retired_count <= '0;
    end else if (flush) begin
      // Bubble: index and data are left as they were.
      wb_valid <= 1'b0;
      regWrite <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= mem_valid;
      regWrite      <= mem_valid & mem_reg_write & (mem_rd != '0);
      WriteRegister <= mem_rd;
      WriteData     <= wb_data;
      if (mem_valid) begin
        retired_count <= retired_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: table-driven vectors through a scoreboard, plus
// reset, stall/flush and counter-wrap sequences on a 32-bit and a 4-bit counter instance.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_pc_plus4;

  logic        regWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        wb_valid;
  logic [31:0] retired_count;

  logic        w_regWrite;
  logic [4:0]  w_WriteRegister;
  logic [31:0] w_WriteData;
  logic        w_wb_valid;
  logic [3:0]  w_retired_count;

  writeback_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_wb_sel    (mem_wb_sel),
    .mem_alu_result(mem_alu_result),
    .mem_load_data (mem_load_data),
    .mem_load_type (mem_load_type),
    .mem_addr_lo   (mem_addr_lo),
    .mem_pc_plus4  (mem_pc_plus4),
    .regWrite      (regWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .wb_valid      (wb_valid),
    .retired_count (retired_count)
  );

  writeback_stage #(.COUNT_W(4)) dut_w4 (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_wb_sel    (mem_wb_sel),
    .mem_alu_result(mem_alu_result),
    .mem_load_data (mem_load_data),
    .mem_load_type (mem_load_type),
    .mem_addr_lo   (mem_addr_lo),
    .mem_pc_plus4  (mem_pc_plus4),
    .regWrite      (w_regWrite),
    .WriteRegister (w_WriteRegister),
    .WriteData     (w_WriteData),
    .wb_valid      (w_wb_valid),
    .retired_count (w_retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [31:0] pc;
    logic        exp_rw;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct {
    string       name;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[16];

  // Reference state of the WB register.
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_valid;
  logic [31:0] m_cnt;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(string n, logic va, logic rw, logic [4:0] rd, logic [1:0] sel,
                              logic [31:0] alu, logic [2:0] lt, logic [1:0] off,
                              logic [31:0] pc, logic erw, logic [31:0] ewd);
    vec_t v;
    v.name = n; v.valid = va; v.rw = rw; v.rd = rd; v.sel = sel; v.alu = alu;
    v.ld = 32'h80FF_7F01; v.lt = lt; v.off = off; v.pc = pc;
    v.exp_rw = erw; v.exp_wd = ewd;
    return v;
  endfunction

  task automatic cmp(string what, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  task automatic check_out(exp_t e);
    cmp({e.name, " regWrite"}, {31'b0, regWrite}, {31'b0, e.rw});
    cmp({e.name, " WriteRegister"}, {27'b0, WriteRegister}, {27'b0, e.rd});
    cmp({e.name, " WriteData"}, WriteData, e.wd);
    cmp({e.name, " wb_valid"}, {31'b0, wb_valid}, {31'b0, e.valid});
    cmp({e.name, " retired_count"}, retired_count, e.cnt);
    cmp({e.name, " retired_count4"}, {28'b0, w_retired_count}, {28'b0, e.cnt[3:0]});
  endtask

  function automatic exp_t model_snapshot(string n);
    exp_t e;
    e.name = n; e.rw = m_rw; e.rd = m_rd; e.wd = m_wd; e.valid = m_valid; e.cnt = m_cnt;
    return e;
  endfunction

  task automatic model_reset();
    m_rw = 1'b0; m_rd = '0; m_wd = '0; m_valid = 1'b0; m_cnt = '0;
    sb.delete();
  endtask

  // Drive one MEM-stage instruction, clock it in, then check one cycle later.
  task automatic apply(vec_t v, logic st, logic fl);
    exp_t e;
    mem_valid      = v.valid;
    mem_reg_write  = v.rw;
    mem_rd         = v.rd;
    mem_wb_sel     = v.sel;
    mem_alu_result = v.alu;
    mem_load_data  = v.ld;
    mem_load_type  = v.lt;
    mem_addr_lo    = v.off;
    mem_pc_plus4   = v.pc;
    stall          = st;
    flush          = fl;
    if (fl) begin
      m_valid = 1'b0;
      m_rw    = 1'b0;
    end else if (!st) begin
      m_valid = v.valid;
      m_rw    = v.exp_rw;
      m_rd    = v.rd;
      m_wd    = v.exp_wd;
      if (v.valid) m_cnt = m_cnt + 1;
    end
    sb.push_back(model_snapshot(v.name));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", v.name);
    end else begin
      e = sb.pop_front();
      check_out(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bubble;
    vec_t v;

    tbl[0]  = mk("alu",    1, 1,  8, 2'd0, 32'h1234_5678, 3'b000, 2'd0, 32'h0, 1, 32'h1234_5678);
    tbl[1]  = mk("lb3",    1, 1,  5, 2'd1, 32'h1111_1111, 3'b011, 2'd3, 32'h0, 1, 32'hFFFF_FF80);
    tbl[2]  = mk("lbu3",   1, 1,  6, 2'd1, 32'h1111_1111, 3'b100, 2'd3, 32'h0, 1, 32'h0000_0080);
    tbl[3]  = mk("lh2",    1, 1,  7, 2'd1, 32'h1111_1111, 3'b001, 2'd2, 32'h0, 1, 32'hFFFF_80FF);
    tbl[4]  = mk("lhu0",   1, 1,  9, 2'd1, 32'h1111_1111, 3'b010, 2'd0, 32'h0, 1, 32'h0000_7F01);
    tbl[5]  = mk("lw1",    1, 1, 10, 2'd1, 32'h1111_1111, 3'b000, 2'd1, 32'h0, 1, 32'h80FF_7F01);
    tbl[6]  = mk("lwdef",  1, 1, 11, 2'd1, 32'h1111_1111, 3'b110, 2'd2, 32'h0, 1, 32'h80FF_7F01);
    tbl[7]  = mk("lb1",    1, 1, 12, 2'd1, 32'h1111_1111, 3'b011, 2'd1, 32'h0, 1, 32'h0000_007F);
    tbl[8]  = mk("lb2",    1, 1, 13, 2'd1, 32'h1111_1111, 3'b011, 2'd2, 32'h0, 1, 32'hFFFF_FFFF);
    tbl[9]  = mk("lhu3",   1, 1, 14, 2'd1, 32'h1111_1111, 3'b010, 2'd3, 32'h0, 1, 32'h0000_80FF);
    tbl[10] = mk("lh1",    1, 1, 15, 2'd1, 32'h1111_1111, 3'b001, 2'd1, 32'h0, 1, 32'h0000_7F01);
    tbl[11] = mk("rd0",    1, 1,  0, 2'd0, 32'hDEAD_BEEF, 3'b000, 2'd0, 32'h0, 0, 32'hDEAD_BEEF);
    tbl[12] = mk("link",   1, 1, 31, 2'd2, 32'h0000_0005, 3'b000, 2'd0, 32'h0040_0010, 1,
                 32'h0040_0010);
    tbl[13] = mk("sel3",   1, 1, 20, 2'd3, 32'hCAFE_F00D, 3'b011, 2'd3, 32'h0040_0010, 1,
                 32'hCAFE_F00D);
    tbl[14] = mk("inval",  0, 1,  3, 2'd0, 32'h0102_0304, 3'b000, 2'd0, 32'h0, 0, 32'h0102_0304);
    tbl[15] = mk("norw",   1, 0,  4, 2'd0, 32'h0BAD_F00D, 3'b000, 2'd0, 32'h0, 0, 32'h0BAD_F00D);
    bubble  = mk("bubble", 0, 0,  0, 2'd0, 32'h0,         3'b000, 2'd0, 32'h0, 0, 32'h0);

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = '0; mem_wb_sel = '0;
    mem_alu_result = '0; mem_load_data = '0; mem_load_type = '0; mem_addr_lo = '0;
    mem_pc_plus4 = '0;
    model_reset();
    #12;
    check_out(model_snapshot("por"));
    @(negedge clk);
    reset = 1'b0;

    // Reset asserted mid-cycle while stalled, with regWrite high.
    apply(mk("pre", 1, 1, 8, 2'd0, 32'h5555_AAAA, 3'b000, 2'd0, 32'h0, 1, 32'h5555_AAAA), 0, 0);
    #2;
    stall = 1'b1;
    mem_valid = 1'b1;
    reset = 1'b1;
    model_reset();
    #1;
    check_out(model_snapshot("async_rst"));
    @(posedge clk);
    #1;
    check_out(model_snapshot("rst_held"));
    @(negedge clk);
    reset = 1'b0;
    apply(bubble, 0, 0);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i], 0, 0);
    end

    // Stall while inputs change, then stall+flush, flush alone, resume.
    apply(mk("st_base", 1, 1, 9, 2'd0, 32'hAAAA_5555, 3'b000, 2'd0, 32'h0, 1, 32'hAAAA_5555), 0, 0);
    for (int i = 0; i < 3; i++) begin
      v = mk("stall", 1, 1, 5'(10 + i), 2'd0, 32'h100 + i, 3'b000, 2'd0, 32'h0, 1, 32'h100 + i);
      apply(v, 1, 0);
    end
    apply(mk("st_fl", 1, 1, 17, 2'd0, 32'h7777_0000, 3'b000, 2'd0, 32'h0, 1, 32'h7777_0000), 1, 1);
    apply(mk("flush", 1, 1, 18, 2'd0, 32'h7777_0001, 3'b000, 2'd0, 32'h0, 1, 32'h7777_0001), 0, 1);
    apply(mk("resume", 1, 1, 19, 2'd2, 32'h0, 3'b000, 2'd0, 32'h0000_1004, 1, 32'h0000_1004), 0, 0);

    // Counter wrap on the 4-bit instance.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_out(model_snapshot("rst2"));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = mk("wrap", 1, 1, 5'(i + 1), 2'd0, 32'(i), 3'b000, 2'd0, 32'h0, 1, 32'(i));
      apply(v, 0, 0);
    end
    cmp("wrap4_zero", {28'b0, w_retired_count}, 32'd0);
    cmp("wrap32_16", retired_count, 32'd16);
    apply(mk("post_wrap", 1, 0, 1, 2'd0, 32'h0, 3'b000, 2'd0, 32'h0, 0, 32'h0), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
